// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// serial_magnitude_comparator: compares two WIDTH-bit operands CHUNK bits per
// cycle, MSB chunk first, stopping at the first differing chunk.
// ============================================================================
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_IN_VALID,
    output logic             o_IN_READY,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    input  logic             i_SIGNED,
    output logic             o_OUT_VALID,
    input  logic             i_OUT_READY,
    output logic             o_A_GT_B,
    output logic             o_A_EQ_B,
    output logic             o_A_LT_B
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_magnitude_comparator: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic             gt_q, eq_q, lt_q;
    logic             gt_nxt, eq_nxt, lt_nxt;
    logic             load;
    logic [WIDTH-1:0] sign_mask, a_cmp, b_cmp;
    logic [CHUNK-1:0] a_chunk, b_chunk;

    // Flipping the sign bit maps two's-complement order onto unsigned order;
    // it only touches the MSB chunk, so it can be applied unconditionally.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = signed_q;
        a_cmp                = a_q ^ sign_mask;
        b_cmp                = b_q ^ sign_mask;
        a_chunk              = '0;
        b_chunk              = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_cmp[i*CHUNK +: CHUNK];
                b_chunk = b_cmp[i*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        gt_nxt    = gt_q;
        eq_nxt    = eq_q;
        lt_nxt    = lt_q;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (i_IN_VALID) begin
                    load      = 1'b1;
                    idx_nxt   = IDX_TOP;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (a_chunk > b_chunk) begin
                    gt_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (a_chunk < b_chunk) begin
                    lt_nxt    = 1'b1;
                    state_nxt = DONE;
                end else if (idx_q == '0) begin
                    eq_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (i_OUT_READY) begin
                    gt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gt_nxt    = 1'b0;
                eq_nxt    = 1'b0;
                lt_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state    <= IDLE;
            idx_q    <= IDX_TOP;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            gt_q  <= gt_nxt;
            eq_q  <= eq_nxt;
            lt_q  <= lt_nxt;
            if (load) begin
                a_q      <= i_OPERAND_A;
                b_q      <= i_OPERAND_B;
                signed_q <= i_SIGNED;
            end
        end
    end

    assign o_IN_READY  = (state == IDLE) & i_RST_N;
    assign o_OUT_VALID = (state == DONE);
    assign o_A_GT_B    = gt_q;
    assign o_A_EQ_B    = eq_q;
    assign o_A_LT_B    = lt_q;

endmodule
`default_nettype wire
